// File: rtl/ctrl_pipe_pkg.sv
// Shared control encodings and control-bundle layouts for the decode, ALU-decode and hazard logic.
package ctrl_pipe_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned RES_W   = 2;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  localparam logic [RES_W-1:0] RES_ALU = 2'b00;
  localparam logic [RES_W-1:0] RES_MEM = 2'b01;
  localparam logic [RES_W-1:0] RES_PC4 = 2'b10;
  localparam logic [RES_W-1:0] RES_IMM = 2'b11;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic               reg_write;
    logic               mem_write;
    logic [RES_W-1:0]   result_src;
    logic               branch;
    logic               branch_ne;
    logic               jump;
    logic               jump_reg;
    logic               alu_src;
    logic               alu_src_a;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_e_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic [RES_W-1:0] result_src;
  } ctrl_m_t;

  typedef struct packed {
    logic             reg_write;
    logic [RES_W-1:0] result_src;
  } ctrl_w_t;

  function automatic ctrl_m_t e_to_m(input ctrl_e_t e);
    ctrl_m_t m;
    m.reg_write  = e.reg_write;
    m.mem_write  = e.mem_write;
    m.result_src = e.result_src;
    return m;
  endfunction

  function automatic ctrl_w_t m_to_w(input ctrl_m_t m);
    ctrl_w_t w;
    w.reg_write  = m.reg_write;
    w.result_src = m.result_src;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder: opcode/funct3 to immediate type, legality and Execute control bundle.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic [OP_W-1:0]  opD,
  input  logic [F3_W-1:0]  funct3D,
  input  logic             validD,
  output logic [IMM_W-1:0] ImmSrcD,
  output logic             IllegalD,
  output ctrl_e_t          o_ctrl
);

  ctrl_e_t          w_ctrl;
  logic [IMM_W-1:0] w_imm;
  logic             w_legal;
  logic             w_use;

  always_comb begin
    w_ctrl  = '0;
    w_imm   = IMM_I;
    w_legal = 1'b1;
    case (opD)
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        w_imm            = IMM_S;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_ITYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_BRANCH: begin
        w_imm         = IMM_B;
        w_ctrl.alu_op = ALU_SUB;
        w_ctrl.branch = 1'b1;
        if (funct3D == F3_BNE && EXT_OPS != 0) w_ctrl.branch_ne = 1'b1;
        else if (funct3D != F3_BEQ)            w_legal = 1'b0;
      end
      OP_JAL: begin
        w_imm             = IMM_J;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        w_imm             = IMM_U;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.result_src = RES_IMM;
        w_legal           = (EXT_OPS != 0);
      end
      OP_AUIPC: begin
        w_imm            = IMM_U;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_src_a = 1'b1;
        w_legal          = (EXT_OPS != 0);
      end
      OP_JALR: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.jump_reg   = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_legal           = (EXT_OPS != 0);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Bubbles and illegal encodings collapse to the all-zero bundle.
  assign w_use    = validD & w_legal;
  assign ImmSrcD  = w_use ? w_imm : IMM_I;
  assign o_ctrl   = w_use ? w_ctrl : '0;
  assign IllegalD = validD & ~w_legal;

endmodule

// File: rtl/ctrl_pipe.sv
// Control path: decode plus ID/EX, EX/MEM, MEM/WB control registers and a saturating illegal-op counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned EXT_OPS   = 1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [OP_W-1:0]      opD,
  input  logic [F3_W-1:0]      funct3D,
  input  logic                 validD,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [IMM_W-1:0]     ImmSrcD,
  output logic                 IllegalD,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 BranchE,
  output logic                 BranchNeE,
  output logic                 JumpE,
  output logic                 JumpRegE,
  output logic                 ALUSrcE,
  output logic                 ALUSrcAE,
  output logic [ALUOP_W-1:0]   ALUOpE,
  output logic [RES_W-1:0]     ResultSrcE,
  output logic [RES_W-1:0]     ResultSrcM,
  output logic [RES_W-1:0]     ResultSrcW,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic [ILL_CNT_W-1:0] IllCnt
);

  ctrl_e_t              w_ctrl_d;
  ctrl_e_t              r_e;
  ctrl_m_t              r_m;
  ctrl_w_t              r_w;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .opD      (opD),
    .funct3D  (funct3D),
    .validD   (validD),
    .ImmSrcD  (ImmSrcD),
    .IllegalD (IllegalD),
    .o_ctrl   (w_ctrl_d)
  );

  // Flush beats stall; a stall holds E and pushes a bubble into Memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e       <= '0;
      r_m       <= '0;
      r_w       <= '0;
      r_ill_cnt <= '0;
    end else begin
      if (FlushE)       r_e <= '0;
      else if (!StallE) r_e <= w_ctrl_d;
      r_m <= StallE ? '0 : e_to_m(r_e);
      r_w <= m_to_w(r_m);
      if (!FlushE && !StallE && IllegalD && (r_ill_cnt != '1))
        r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
    end
  end

  assign RegWriteE  = r_e.reg_write;
  assign MemWriteE  = r_e.mem_write;
  assign BranchE    = r_e.branch;
  assign BranchNeE  = r_e.branch_ne;
  assign JumpE      = r_e.jump;
  assign JumpRegE   = r_e.jump_reg;
  assign ALUSrcE    = r_e.alu_src;
  assign ALUSrcAE   = r_e.alu_src_a;
  assign ALUOpE     = r_e.alu_op;
  assign ResultSrcE = r_e.result_src;
  assign RegWriteM  = r_m.reg_write;
  assign MemWriteM  = r_m.mem_write;
  assign ResultSrcM = r_m.result_src;
  assign RegWriteW  = r_w.reg_write;
  assign ResultSrcW = r_w.result_src;
  assign IllCnt     = r_ill_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: default config and an EXT_OPS=0 / ILL_CNT_W=2 copy share one stimulus stream.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       regw;
    logic       memw;
    logic [1:0] rsrc;
    logic       br;
    logic       brne;
    logic       jmp;
    logic       jr;
    logic       asrc;
    logic       asrca;
    logic [1:0] aop;
  } eb_t;

  typedef struct packed {
    logic       illegal;
    logic [2:0] imm;
    eb_t        eb;
  } dres_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opD = '0;
  logic [2:0] funct3D = '0;
  logic       validD = 1'b0;
  logic       StallE = 1'b0;
  logic       FlushE = 1'b0;

  // index 1: default config, index 0: EXT_OPS=0, ILL_CNT_W=2
  logic [2:0] imm1, imm0;
  logic       ill1, ill0;
  logic       rwE1, mwE1, brE1, bneE1, jE1, jrE1, asE1, asaE1;
  logic       rwE0, mwE0, brE0, bneE0, jE0, jrE0, asE0, asaE0;
  logic [1:0] aopE1, rsE1, rsM1, rsW1, aopE0, rsE0, rsM0, rsW0;
  logic       rwM1, mwM1, rwW1, rwM0, mwM0, rwW0;
  logic [7:0] cnt1;
  logic [1:0] cnt0;

  ctrl_pipe dut (
    .clk(clk), .reset_n(reset_n), .opD(opD), .funct3D(funct3D), .validD(validD),
    .StallE(StallE), .FlushE(FlushE), .ImmSrcD(imm1), .IllegalD(ill1),
    .RegWriteE(rwE1), .MemWriteE(mwE1), .BranchE(brE1), .BranchNeE(bneE1), .JumpE(jE1),
    .JumpRegE(jrE1), .ALUSrcE(asE1), .ALUSrcAE(asaE1), .ALUOpE(aopE1), .ResultSrcE(rsE1),
    .ResultSrcM(rsM1), .ResultSrcW(rsW1), .RegWriteM(rwM1), .MemWriteM(mwM1),
    .RegWriteW(rwW1), .IllCnt(cnt1)
  );

  ctrl_pipe #(.EXT_OPS(0), .ILL_CNT_W(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .opD(opD), .funct3D(funct3D), .validD(validD),
    .StallE(StallE), .FlushE(FlushE), .ImmSrcD(imm0), .IllegalD(ill0),
    .RegWriteE(rwE0), .MemWriteE(mwE0), .BranchE(brE0), .BranchNeE(bneE0), .JumpE(jE0),
    .JumpRegE(jrE0), .ALUSrcE(asE0), .ALUSrcAE(asaE0), .ALUOpE(aopE0), .ResultSrcE(rsE0),
    .ResultSrcM(rsM0), .ResultSrcW(rsW0), .RegWriteM(rwM0), .MemWriteM(mwM0),
    .RegWriteW(rwW0), .IllCnt(cnt0)
  );

  always #5 clk = ~clk;

  eb_t aE[2], aM[2], aW[2];
  assign aE[1] = {rwE1, mwE1, rsE1, brE1, bneE1, jE1, jrE1, asE1, asaE1, aopE1};
  assign aE[0] = {rwE0, mwE0, rsE0, brE0, bneE0, jE0, jrE0, asE0, asaE0, aopE0};
  assign aM[1] = {rwM1, mwM1, rsM1, 8'h00};
  assign aM[0] = {rwM0, mwM0, rsM0, 8'h00};
  assign aW[1] = {rwW1, 1'b0, rsW1, 8'h00};
  assign aW[0] = {rwW0, 1'b0, rsW0, 8'h00};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table.
  function automatic dres_t dec(input logic [6:0] op, input logic [2:0] f3,
                                input logic v, input bit ext);
    dres_t r;
    bit ok;
    r = '0;
    ok = 1'b1;
    case (op)
      7'b0000011: begin r.eb.regw = 1; r.eb.asrc = 1; r.eb.rsrc = 2'b01; end
      7'b0100011: begin r.imm = 3'b001; r.eb.asrc = 1; r.eb.memw = 1; end
      7'b0110011: begin r.eb.regw = 1; r.eb.aop = 2'b10; end
      7'b0010011: begin r.eb.regw = 1; r.eb.asrc = 1; r.eb.aop = 2'b10; end
      7'b1100011: begin
        r.imm = 3'b010; r.eb.br = 1; r.eb.aop = 2'b01;
        if (f3 == 3'b001 && ext) r.eb.brne = 1;
        else if (f3 != 3'b000) ok = 0;
      end
      7'b1101111: begin r.imm = 3'b011; r.eb.regw = 1; r.eb.jmp = 1; r.eb.rsrc = 2'b10; end
      7'b0110111: begin r.imm = 3'b100; r.eb.regw = 1; r.eb.rsrc = 2'b11; ok = ext; end
      7'b0010111: begin
        r.imm = 3'b100; r.eb.regw = 1; r.eb.asrc = 1; r.eb.asrca = 1; ok = ext;
      end
      7'b1100111: begin
        r.eb.regw = 1; r.eb.asrc = 1; r.eb.jr = 1; r.eb.rsrc = 2'b10; ok = ext;
      end
      default: ok = 0;
    endcase
    if (!(v && ok)) begin r.imm = '0; r.eb = '0; end
    r.illegal = v && !ok;
    return r;
  endfunction

  function automatic eb_t keep_m(input eb_t e);
    eb_t r = '0;
    r.regw = e.regw; r.memw = e.memw; r.rsrc = e.rsrc;
    return r;
  endfunction

  function automatic eb_t keep_w(input eb_t e);
    eb_t r = '0;
    r.regw = e.regw; r.rsrc = e.rsrc;
    return r;
  endfunction

  eb_t mE[2] = '{default: '0};
  eb_t mM[2] = '{default: '0};
  eb_t mW[2] = '{default: '0};
  int  mCnt[2] = '{default: 0};

  // Stage-level model: each stage takes its predecessor's value per the hazard rules.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        mE[c] <= '0; mM[c] <= '0; mW[c] <= '0; mCnt[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        dres_t d;
        int cmax;
        d = dec(opD, funct3D, validD, c == 1);
        cmax = (c == 1) ? 255 : 3;
        mW[c] <= keep_w(mM[c]);
        mM[c] <= StallE ? '0 : keep_m(mE[c]);
        if (FlushE) mE[c] <= '0;
        else if (!StallE) mE[c] <= d.eb;
        if (!FlushE && !StallE && d.illegal && mCnt[c] < cmax) mCnt[c] <= mCnt[c] + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    dres_t d1, d0;
    d1 = dec(opD, funct3D, validD, 1'b1);
    d0 = dec(opD, funct3D, validD, 1'b0);
    chk("E_bundle_ext1", 32'(aE[1]), 32'(mE[1]));
    chk("M_bundle_ext1", 32'(aM[1]), 32'(mM[1]));
    chk("W_bundle_ext1", 32'(aW[1]), 32'(mW[1]));
    chk("IllCnt_ext1",   32'(cnt1),  32'(mCnt[1]));
    chk("ImmSrcD_ext1",  32'(imm1),  32'(d1.imm));
    chk("IllegalD_ext1", 32'(ill1),  32'(d1.illegal));
    chk("E_bundle_ext0", 32'(aE[0]), 32'(mE[0]));
    chk("M_bundle_ext0", 32'(aM[0]), 32'(mM[0]));
    chk("W_bundle_ext0", 32'(aW[0]), 32'(mW[0]));
    chk("IllCnt_ext0",   32'(cnt0),  32'(mCnt[0]));
    chk("ImmSrcD_ext0",  32'(imm0),  32'(d0.imm));
    chk("IllegalD_ext0", 32'(ill0),  32'(d0.illegal));
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic v,
                       input logic st, input logic fl);
    opD = op; funct3D = f3; validD = v; StallE = st; FlushE = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops[10];
  logic [1:0] sat_exp[5];

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    #12;
    chk("reset_E", 32'(aE[1]), 32'h0);
    chk("reset_W", 32'(aW[1]), 32'h0);
    chk("reset_cnt", 32'(cnt1), 32'h0);
    reset_n = 1'b1;

    // lw through the pipe
    drive(7'b0000011, 3'b010, 1, 0, 0); tick;
    chk("lw_RegWriteE", 32'(rwE1), 32'h1);
    chk("lw_ALUSrcE", 32'(asE1), 32'h1);
    chk("lw_ResultSrcE", 32'(rsE1), 32'h1);
    drive(7'b0, 3'b0, 0, 0, 0); tick; tick;
    chk("lw_RegWriteW", 32'(rwW1), 32'h1);
    chk("lw_ResultSrcW", 32'(rsW1), 32'h1);

    // sw squashed by FlushE
    drive(7'b0100011, 3'b010, 1, 0, 1); tick;
    chk("sw_flush_E", 32'(aE[1]), 32'h0);
    drive(7'b0, 3'b0, 0, 0, 0); tick;
    chk("sw_flush_MemWriteM", 32'(mwM1), 32'h0);

    // beq held two cycles under StallE
    drive(7'b0000011, 3'b010, 1, 0, 0); tick;
    drive(7'b1100011, 3'b000, 1, 0, 0); tick;
    chk("beq_BranchE", 32'(brE1), 32'h1);
    chk("beq_prev_lw_M", 32'(rwM1), 32'h1);
    for (int k = 0; k < 2; k++) begin
      drive(7'b1101111, 3'b000, 1, 1, 0); tick;
      chk("stall_BranchE", 32'(brE1), 32'h1);
      chk("stall_M_zero", 32'(aM[1]), 32'h0);
    end

    // lui with and without extended ops
    drive(7'b0110111, 3'b000, 1, 0, 0); #1;
    chk("lui_IllegalD_ext0", 32'(ill0), 32'h1);
    chk("lui_ImmSrcD_ext0", 32'(imm0), 32'h0);
    chk("lui_ImmSrcD_ext1", 32'(imm1), 32'h4);
    tick;
    chk("lui_E_zero_ext0", 32'(aE[0]), 32'h0);
    chk("lui_cnt_ext0", 32'(cnt0), 32'h1);
    chk("lui_ResultSrcE_ext1", 32'(rsE1), 32'h3);
    chk("lui_cnt_ext1", 32'(cnt1), 32'h0);

    // saturation of the 2-bit counter after a short reset pulse
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(7'b0000000, 3'b000, 1, 0, 0); tick;
      chk("sat_cnt_ext0", 32'(cnt0), 32'(sat_exp[k]));
      chk("sat_cnt_ext1", 32'(cnt1), 32'(k + 1));
    end

    // asynchronous reset with jal in Execute
    drive(7'b0000011, 3'b010, 1, 0, 0); tick; tick;
    drive(7'b1101111, 3'b000, 1, 0, 0); tick;
    chk("jal_JumpE", 32'(jE1), 32'h1);
    chk("jal_RegWriteW", 32'(rwW1), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_JumpE", 32'(jE1), 32'h0);
    chk("arst_RegWriteM", 32'(rwM1), 32'h0);
    chk("arst_RegWriteW", 32'(rwW1), 32'h0);
    #3 reset_n = 1'b1;

    // randomized stream, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      drive(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 15) == 0) funct3D = 3'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) opD = 7'($urandom_range(0, 127));
      tick;
      if (i == 1500) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter EXT_OPS, default 1, meaning 1 = also decode lui/auipc/jalr/bne; 0 = only lw, sw, R-type, I-type ALU, beq, jal.
REQ-002 Parameter ILL_CNT_W, default 8, meaning width of the saturating illegal-instruction counter.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 opD  input  7  opcode of the instruction in Decode.
REQ-006 funct3D  input  3  funct3 of the instruction in Decode.
REQ-007 validD  input  1  Decode holds a real instruction; 0 = bubble.
REQ-008 StallE, FlushE  input  1 each  hazard-unit controls for the ID/EX control register.
REQ-009 ImmSrcD  output  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U; combinational from opD.
REQ-010 IllegalD  output  1  combinational; validD=1 and opcode/funct3 not supported under the current EXT_OPS.
REQ-011 RegWriteE, MemWriteE, BranchE, BranchNeE, JumpE, JumpRegE, ALUSrcE, ALUSrcAE  output  1 each  Execute-stage controls.
REQ-012 ALUOpE  output  2  Execute ALU op class: 00 add, 01 sub, 10 funct-decoded.
REQ-013 ResultSrcE, ResultSrcM, ResultSrcW  output  2 each  result select: 00 ALU, 01 memory, 10 PC+4, 11 immediate (lui).
REQ-014 RegWriteM, MemWriteM, RegWriteW  output  1 each  Memory/Writeback controls.
REQ-015 IllCnt  output  ILL_CNT_W  count of illegal instructions that have entered Execute.

Function
REQ-016 Decode SHALL produce: lw 1_000_1_0_01; sw 0_001_1_1_00; R-type 1_xxx_0_0_00 with ALUOp 10; beq Branch=1, ALUOp 01, ImmSrc 010; I-type ALU 1_000_1_0_00 with ALUOp 10; jal Jump=1, ResultSrc 10, ImmSrc 011 (fields RegWrite_ImmSrc_ALUSrc_MemWrite_ResultSrc).
REQ-017 With EXT_OPS=1: lui RegWrite, ImmSrc 100, ResultSrc 11; auipc RegWrite, ImmSrc 100, ALUSrcA=1, ALUSrc=1, ALUOp 00; jalr RegWrite, ImmSrc 000, ALUSrc=1, JumpRegE=1, ResultSrc 10; opcode 1100011 with funct3 001 SHALL set Branch and BranchNe.
REQ-018 A branch opcode with funct3 other than 000 (or 001 when EXT_OPS=1) SHALL be illegal.
REQ-019 Illegal or validD=0 instructions SHALL decode to the all-zero bundle (no x values anywhere); ImmSrcD SHALL be 000 for them.
REQ-020 ID/EX control register update priority per cycle: FlushE -> load all-zero bundle; else StallE -> hold; else load decoded bundle.
REQ-021 EX/MEM register SHALL load the E bundle every cycle, except it SHALL load all-zero when StallE=1 (bubble into Memory).
REQ-022 MEM/WB register SHALL load the M bundle every cycle.
REQ-023 Latency: a decoded instruction's controls appear on E outputs 1 cycle, M outputs 2 cycles, W outputs 3 cycles after the Decode cycle, barring stall/flush.
REQ-024 IllCnt SHALL increment by 1 on each cycle in which an illegal instruction is loaded into ID/EX (FlushE=0, StallE=0, IllegalD=1), and SHALL saturate at all-ones.
REQ-025 FlushE and StallE both asserted: flush wins; the IllCnt increment is suppressed.

Reset
REQ-026 reset_n=0 SHALL immediately clear every E, M, W output bundle and IllCnt to zero, regardless of clk.
REQ-027 Reset deassertion mid-stream SHALL leave three cycles of bubbles (all-zero controls) ahead of the first newly decoded instruction at W.

Structure
REQ-028 Opcode constants, ImmSrc/ResultSrc/ALUOp encodings, and the control-bundle field layout SHALL live in a shared package also used by the ALU decoder and hazard unit.
REQ-029 One sub-module, ctrl_decode, SHALL hold the combinational opcode decode; ctrl_pipe SHALL hold the three pipeline registers and counter.

Verification
REQ-030 Reset, then lw (0000011) in D -> next cycle RegWriteE=1, ALUSrcE=1, ResultSrcE=01; cycle 3 RegWriteW=1, ResultSrcW=01.
REQ-031 sw in D with FlushE=1 -> next cycle all E outputs 0; cycle after, MemWriteM=0.
REQ-032 beq held in ID/EX with StallE=1 for 2 cycles -> BranchE stays 1 both cycles; M bundle all-zero both cycles.
REQ-033 EXT_OPS=0, lui (0110111) in D -> IllegalD=1, ImmSrcD=000, E bundle zero, IllCnt 0->1; EXT_OPS=1, same -> ImmSrcD=100, ResultSrcE=11, IllCnt unchanged.
REQ-034 ILL_CNT_W=2, five illegal opcodes (0000000) back-to-back -> IllCnt 1,2,3,3,3.
REQ-035 reset_n pulled low between clock edges with jal in Execute -> JumpE, RegWriteM, RegWriteW drop to 0 before the next clk edge.
